axo_bram_ctrl: RTL and testbench

Request/response front-end for the single-port simulation block RAM, sitting directly upstream of it. Accepts byte-addressed read/write requests from the simulated bus over a valid/ready handshake and drives the RAM's per-byte write enable, word address and write data. Captures the RAM's registered read data into a 2-entry response buffer, so bus backpressure never drops data. Sustains one request per cycle when the response side is not stalled.

---
 rtl/axo_bram_ctrl.sv | 93 +++++++++
 tb/tb_axo_bram_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/axo_bram_ctrl.sv
// Valid/ready front-end for a single-port block RAM with a 2-entry response buffer.
// Optional misaligned-access rejection: define AXO_BRAM_CTRL_ALIGN_CHECK_EN.
module axo_bram_ctrl #(
  parameter  int abits  = 8,
  parameter  int dbytes = 4,
  parameter  int blen   = 8,
  localparam int dbits  = dbytes * blen,
  localparam int obits  = $clog2(dbytes),
  localparam int babits = abits + obits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [babits-1:0] req_addr,
  input  logic [dbytes-1:0] req_we,
  input  logic [dbits-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [dbits-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [dbytes-1:0] ram_we,
  output logic [abits-1:0]  ram_addr,
  output logic [dbits-1:0]  ram_wdata,
  input  logic [dbits-1:0]  ram_rdata
);

  typedef struct packed {
    logic             err;
    logic [dbits-1:0] rdata;
  } resp_t;

  logic       w_accept, w_pop, w_err;
  logic [2:0] w_occ;
  resp_t      w_head, w_push_ent;

  logic       r_inflight, r_if_write, r_if_err;
  logic       r_wptr, r_rptr;
  logic [1:0] r_cnt;
  resp_t      r_buf [2];

`ifdef AXO_BRAM_CTRL_ALIGN_CHECK_EN
  assign w_err = |(req_addr & babits'(dbytes - 1));
`else
  logic w_unused_addr;
  assign w_unused_addr = |(req_addr & babits'(dbytes - 1));
  assign w_err = 1'b0;
`endif

  assign ram_addr  = req_addr[babits-1:obits];
  assign ram_wdata = req_wdata;

  // Slots already committed (buffered + in flight) net of this cycle's pop.
  assign w_pop     = resp_valid & resp_ready;
  assign w_occ     = 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign req_ready = rst_n & (w_occ < 3'd2);
  assign w_accept  = req_valid & req_ready;
  assign ram_we    = (w_accept & ~w_err) ? req_we : '0;

  assign w_push_ent.err   = r_if_err;
  assign w_push_ent.rdata = (r_if_write | r_if_err) ? '0 : ram_rdata;

  assign w_head     = r_buf[r_rptr];
  assign resp_valid = (r_cnt != 2'd0);
  assign resp_rdata = resp_valid ? w_head.rdata : '0;
  assign resp_err   = resp_valid & w_head.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_if_write <= 1'b0;
      r_if_err   <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_if_write <= |req_we;
        r_if_err   <= w_err;
      end
      if (r_inflight) r_wptr <= ~r_wptr;
      if (w_pop)      r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end

  // Storage needs no reset: the count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (r_inflight) r_buf[r_wptr] <= w_push_ent;
  end

endmodule

// File: tb/tb_axo_bram_ctrl.sv
// Directed self-checking bench for axo_bram_ctrl with a behavioural byte-enable RAM.
// Misaligned-request checks are built only when AXO_BRAM_CTRL_ALIGN_CHECK_EN is defined.
module tb_axo_bram_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [9:0]  req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  axo_bram_ctrl #(.abits(8), .dbytes(4), .blen(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [31:0] exp_word(input int w);
    if (w == 4) return 32'hDEADAAEF;
    return 32'hA5A50000 + 32'(w);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated request with resp_ready high; response checked two edges after accept.
  task automatic do_req(input string tag, input logic [9:0] addr, input logic [3:0] we,
                        input logic [31:0] wd, input logic [3:0] exp_we,
                        input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wd; resp_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
    chk({tag, "_ramwe"}, 64'(ram_we), 64'(exp_we));
    chk({tag, "_ramaddr"}, 64'(ram_addr), 64'(addr[9:2]));
    @(negedge clk);
    req_valid = 1'b0; req_we = 4'h0;
    #1;
    chk({tag, "_early"}, 64'(resp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, 64'(resp_valid), 64'd1);
    chk({tag, "_rdata"}, 64'(resp_rdata), 64'(exp_rd));
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
  endtask

  initial begin
    int acc, got;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 + 32'(i);
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0;
    resp_ready = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_ramwe", 64'(ram_we), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Full write, read-back, then a single-byte write over byte 1.
    do_req("wr_full", 10'h010, 4'hF, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    do_req("rd_full", 10'h010, 4'h0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    do_req("wr_byte", 10'h010, 4'b0010, 32'h0000AA00, 4'b0010, 32'h0, 1'b0);
    do_req("rd_byte", 10'h010, 4'h0, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);

    // 16 back-to-back reads, one response per cycle in address order.
    resp_ready = 1'b1;
    for (int n = 0; n < 19; n++) begin
      @(negedge clk);
      if (n < 16) begin
        req_valid = 1'b1; req_addr = 10'(n * 4); req_we = 4'h0;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (n >= 2 && n < 18) begin
        chk($sformatf("b2b_vld%0d", n - 2), 64'(resp_valid), 64'd1);
        chk($sformatf("b2b_data%0d", n - 2), 64'(resp_rdata), 64'(exp_word(n - 2)));
      end
      if (n < 16) chk($sformatf("b2b_rdy%0d", n), 64'(req_ready), 64'd1);
      if (n == 18) chk("b2b_drain", 64'(resp_valid), 64'd0);
    end

    // Backpressure: four reads of words 8..11 with resp_ready low for four cycles.
    acc = 0; got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      resp_ready = (n >= 4);
      req_valid  = (acc < 4);
      req_addr   = 10'(32 + acc * 4);
      req_we     = 4'h0;
      #1;
      if (n == 2) chk("bp_head", 64'(resp_rdata), 64'(exp_word(8)));
      if (n == 3) begin
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_rdy_low", 64'(req_ready), 64'd0);
        chk("bp_hold_vld", 64'(resp_valid), 64'd1);
        chk("bp_hold_data", 64'(resp_rdata), 64'(exp_word(8)));
      end
      if (resp_valid && resp_ready) begin
        chk($sformatf("bp_resp%0d", got), 64'(resp_rdata), 64'(exp_word(8 + got)));
        got++;
      end
      if (req_valid && req_ready) acc++;
    end
    req_valid = 1'b0;
    chk("bp_total_resp", 64'(got), 64'd4);
    chk("bp_total_acc", 64'(acc), 64'd4);

`ifdef AXO_BRAM_CTRL_ALIGN_CHECK_EN
    do_req("mis_wr", 10'h013, 4'hF, 32'h11111111, 4'h0, 32'h0, 1'b1);
    do_req("mis_rd", 10'h010, 4'h0, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);
`endif

    // Reset with two responses buffered; a write presented during reset must not reach RAM.
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 10'h004; req_we = 4'h0;
    @(negedge clk);
    req_addr = 10'h008;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_vld_before", 64'(resp_valid), 64'd1);
    chk("rstmid_data_before", 64'(resp_rdata), 64'(exp_word(1)));
    rst_n = 1'b0;
    req_valid = 1'b1; req_addr = 10'h000; req_we = 4'hF; req_wdata = 32'h12345678;
    #1;
    chk("rstmid_vld", 64'(resp_valid), 64'd0);
    chk("rstmid_rdy", 64'(req_ready), 64'd0);
    chk("rstmid_ramwe", 64'(ram_we), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; req_we = 4'h0; resp_ready = 1'b1;
    #1;
    chk("rstrel_rdy", 64'(req_ready), 64'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstrel_nostale%0d", n), 64'(resp_valid), 64'd0);
    end
    do_req("rd_after_rst", 10'h000, 4'h0, 32'h0, 4'h0, 32'hA5A50000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
